bank_access_arbiter: RTL and testbench
======================================

# bank_access_arbiter

Shares one single-ported bank of BLOCK_COUNT parallel block RAMs between the HDMI capture writer and the matrix-output reader. Each granted access becomes one registered bank cycle. Write data is split across the blocks by the block distributor, with a per-block write-enable mask. Read data is returned READ_LATENCY cycles after the bank cycle, tagged with a valid strobe. The arbiter sits between the capture/readout sequencers and the bank inside each single buffer of the double buffer.

## Interface
- BLOCK_COUNT, 4: number of block RAMs in the bank.
- BLOCK_DATA_WIDTH, 32: data width of one block.
- BANDWIDTH, BLOCK_COUNT*BLOCK_DATA_WIDTH: full bank word width.
- ADDR_WIDTH, 9: bank word address width.
- READ_LATENCY, 1: block RAM read latency in cycles (≥1).
- STARVE_LIMIT, 8: maximum consecutive write grants while a read is pending (guard build only, ≥1).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write granted this cycle.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  BANDWIDTH  write word; block i occupies bits [(i+1)*BLOCK_DATA_WIDTH-1 -: BLOCK_DATA_WIDTH].
- wr_mask  in  BLOCK_COUNT  per-block write enable.
- rd_valid  in  1  read request.
- rd_ready  out  1  read granted this cycle.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data_valid  out  1  rd_data holds returned word.
- rd_data  out  BANDWIDTH  returned read word.
- bank_en  out  1  bank cycle active.
- bank_we  out  BLOCK_COUNT  per-block write enable.
- bank_addr  out  ADDR_WIDTH  bank address.
- bank_wdata  out  BANDWIDTH  bank write word, passed to the block distributor.
- bank_rdata  in  BANDWIDTH  bank read word, valid READ_LATENCY cycles after bank_en with bank_we==0.

## Operation
- **Grant rules (combinational):**
  - wr_ready = !(rd_valid && force_read).
  - rd_ready = !wr_valid || force_read.
  - A handshake is valid && ready.
  - At most one handshake per cycle. When both requests are present, the write wins unless force_read is set.
- **Starvation counter** starve_cnt, width $clog2(STARVE_LIMIT+1):
  - +1 on a write handshake while rd_valid=1.
  - Cleared on a read handshake, or in any cycle with rd_valid=0.
  - Saturates at STARVE_LIMIT.
  - force_read = (starve_cnt == STARVE_LIMIT).
- **Bank cycle (registered), in the cycle after a handshake:**
  - bank_en=1.
  - Write handshake: bank_we = wr_mask, bank_addr = wr_addr, bank_wdata = wr_data.
  - Read handshake: bank_we = 0, bank_addr = rd_addr. bank_wdata holds its previous value.
  - No handshake: bank_en=0, bank_we=0.
- **Write mask:**
  - wr_mask=0 is a legal no-op write. It still consumes a bank cycle and counts as a write grant.
- **Read return:**
  - A pipeline of 1+READ_LATENCY valid bits tracks each read.
  - The returned word is captured from bank_rdata into rd_data.
  - rd_data holds its value between returns.
- **Same-address write then read:**
  - A write to address A followed by a read of A in the next cycle returns the new data. The bank write precedes the bank read.
  - No forwarding is performed.
- **Reset:**
  - Applies in any cycle, including mid-read.
  - All outputs go to 0; starve_cnt=0; the read pipeline is flushed.
  - In-flight reads are discarded and produce no rd_data_valid.
- **During rst=1:** wr_ready=0 and rd_ready=0.

## Timing
- Read handshake at cycle t:
  - bank_en at t+1.
  - rd_data_valid pulses for one cycle at t+1+READ_LATENCY.
- Write handshake at t: bank write at t+1.
- Throughput: one access per cycle, in any mix.
- Requesters must hold valid and payload until ready.

## Configuration
- Macro: BANK_ACCESS_ARBITER_STARVE_GUARD_EN.
  - Defined: starvation counter and force_read behave as above.
  - Undefined: strict write priority. force_read is constant 0 and no counter is synthesized. The reader may starve indefinitely under back-to-back writes.

## Structure
- Package bank_pkg holds:
  - the BLOCK_COUNT, BLOCK_DATA_WIDTH and ADDR_WIDTH defaults;
  - typedef bank_word_t [BANDWIDTH];
  - typedef bank_addr_t [ADDR_WIDTH];
  - typedef block_mask_t [BLOCK_COUNT].
- Sub-module bank_rd_pipe: a parameterised valid delay line of depth 1+READ_LATENCY with synchronous clear. It drives rd_data_valid and the rd_data capture enable.

## Test plan
- **Single read:** rd_valid=1, rd_addr=0x012, bank model returns 0xDEADBEEF_... (READ_LATENCY=1) -> rd_ready=1 at t, bank_en=1, bank_we=0, bank_addr=0x012 at t+1, rd_data_valid=1 with that word at t+2.
- **Masked write:** wr_mask=4'b0101, wr_addr=0x005 -> at t+1 bank_we=4'b0101 and bank_addr=0x005; only blocks 0 and 2 of the model change.
- **Contention with guard (STARVE_LIMIT=8):** wr_valid and rd_valid held high -> 8 write grants, then 1 read grant, then writes resume; the pattern repeats every 9 cycles.
- **Contention without guard:** same stimulus with the macro undefined -> rd_ready stays 0 for 100 cycles; after wr_valid drops, the read is granted the next cycle.
- **Reset mid-read:** rst=1 one cycle after a read handshake -> no rd_data_valid is ever seen; all outputs are 0 the cycle after rst.
- **Write-then-read same address:** write 0xA5A5... to 0x010, read 0x010 the next cycle -> returned data equals 0xA5A5....

Source files
------------

// File: rtl/bank_pkg.sv
// Shared defaults and types for the block-RAM bank access path.
package bank_pkg;

    localparam int DEF_BLOCK_COUNT      = 4;
    localparam int DEF_BLOCK_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH       = 9;
    localparam int DEF_BANDWIDTH        = DEF_BLOCK_COUNT * DEF_BLOCK_DATA_WIDTH;

    typedef logic [DEF_BANDWIDTH-1:0]   bank_word_t;
    typedef logic [DEF_ADDR_WIDTH-1:0]  bank_addr_t;
    typedef logic [DEF_BLOCK_COUNT-1:0] block_mask_t;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_READ  = 2'd2
    } access_t;

endpackage

// File: rtl/bank_rd_pipe.sv
// Valid delay line tracking reads from grant to data return; the last stage
// both flags the returned word and enables its capture.
module bank_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    // Shift one stage per cycle, new grant enters at bit 0
    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], in_valid};
    end

    // Pipeline state with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_valid = pipe_q[DEPTH-1];

endmodule

// File: rtl/bank_access_arbiter.sv
// Arbitrates the capture writer and the readout reader onto one single-ported bank.
// Optional read starvation guard: define BANK_ACCESS_ARBITER_STARVE_GUARD_EN.
module bank_access_arbiter
    import bank_pkg::*;
#(
    parameter int BLOCK_COUNT      = DEF_BLOCK_COUNT,
    parameter int BLOCK_DATA_WIDTH = DEF_BLOCK_DATA_WIDTH,
    parameter int BANDWIDTH        = BLOCK_COUNT * BLOCK_DATA_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int READ_LATENCY     = 1,
    parameter int STARVE_LIMIT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [BANDWIDTH-1:0]   wr_data,
    input  logic [BLOCK_COUNT-1:0] wr_mask,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_data_valid,
    output logic [BANDWIDTH-1:0]   rd_data,
    output logic                   bank_en,
    output logic [BLOCK_COUNT-1:0] bank_we,
    output logic [ADDR_WIDTH-1:0]  bank_addr,
    output logic [BANDWIDTH-1:0]   bank_wdata,
    input  logic [BANDWIDTH-1:0]   bank_rdata
);

    logic    force_read_s;
    access_t access_s;
    logic    rd_cap_s;

    logic                   bank_en_q,    bank_en_d;
    logic [BLOCK_COUNT-1:0] bank_we_q,    bank_we_d;
    logic [ADDR_WIDTH-1:0]  bank_addr_q,  bank_addr_d;
    logic [BANDWIDTH-1:0]   bank_wdata_q, bank_wdata_d;
    logic [BANDWIDTH-1:0]   rd_data_q,    rd_data_d;

    // Grant outputs; both suppressed while in reset
    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        if (rst) begin
            wr_ready = 1'b0;
            rd_ready = 1'b0;
        end else begin
            wr_ready = !(rd_valid && force_read_s);
            rd_ready = !wr_valid || force_read_s;
        end
    end

    // Resolve this cycle's single handshake
    always_comb begin
        if (wr_valid && wr_ready) begin
            access_s = ACC_WRITE;
        end else if (rd_valid && rd_ready) begin
            access_s = ACC_READ;
        end else begin
            access_s = ACC_IDLE;
        end
    end

`ifdef BANK_ACCESS_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Count writes that overtook a waiting reader; any read service or idle reader clears
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!rd_valid || (access_s == ACC_READ)) begin
            starve_cnt_d = '0;
        end else if ((access_s == ACC_WRITE) && (starve_cnt_q != LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_read_s = (starve_cnt_q == LIMIT_C);
`else
    assign force_read_s = 1'b0;
`endif

    // Next bank cycle; address and write word hold when not refreshed
    always_comb begin
        bank_en_d    = 1'b0;
        bank_we_d    = '0;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
        case (access_s)
            ACC_WRITE: begin
                bank_en_d    = 1'b1;
                bank_we_d    = wr_mask;
                bank_addr_d  = wr_addr;
                bank_wdata_d = wr_data;
            end
            ACC_READ: begin
                bank_en_d   = 1'b1;
                bank_we_d   = '0;
                bank_addr_d = rd_addr;
            end
            default: begin
                bank_en_d = 1'b0;
                bank_we_d = '0;
            end
        endcase
    end

    // Returned word is kept until the next return
    always_comb begin
        if (rd_cap_s) begin
            rd_data_d = bank_rdata;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Bank cycle and read-hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_en_q    <= 1'b0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            rd_data_q    <= '0;
        end else begin
            bank_en_q    <= bank_en_d;
            bank_we_q    <= bank_we_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            rd_data_q    <= rd_data_d;
        end
    end

    bank_rd_pipe #(
        .DEPTH (1 + READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (access_s == ACC_READ),
        .out_valid (rd_cap_s)
    );

    assign bank_en       = bank_en_q;
    assign bank_we       = bank_we_q;
    assign bank_addr     = bank_addr_q;
    assign bank_wdata    = bank_wdata_q;
    assign rd_data_valid = rd_cap_s;
    // bank_rdata is only valid during the return cycle, so it is passed through then
    assign rd_data       = rd_cap_s ? bank_rdata : rd_data_q;

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Self-checking bench for bank_access_arbiter with a behavioural bank and access model.
module tb_bank_access_arbiter;
    import bank_pkg::*;

    localparam int BC  = 4;
    localparam int BDW = 32;
    localparam int BW  = BC * BDW;
    localparam int AW  = 9;
    localparam int RL  = 1;
    localparam int SL  = 8;
`ifdef BANK_ACCESS_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid, bank_en;
    logic [AW-1:0] wr_addr, rd_addr, bank_addr;
    logic [BW-1:0] wr_data, rd_data, bank_wdata, bank_rdata;
    logic [BC-1:0] wr_mask, bank_we;
    logic          mem_init;

    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] mem     [0:(1<<AW)-1];
    logic [BW-1:0] ref_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    bank_access_arbiter #(
        .BLOCK_COUNT(BC), .BLOCK_DATA_WIDTH(BDW), .BANDWIDTH(BW), .ADDR_WIDTH(AW),
        .READ_LATENCY(RL), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    function automatic logic [BW-1:0] init_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {23'd0, a};
        return {32'hC0DE_0000 | x, 32'hBEEF_0000 | x, 32'h5A5A_0000 | x, 32'h1234_0000 | x};
    endfunction

    function automatic logic [BW-1:0] merge(input logic [BW-1:0] old_w,
                                             input logic [BW-1:0] new_w,
                                             input logic [BC-1:0] m);
        logic [BW-1:0] r;
        r = old_w;
        for (int i = 0; i < BC; i++)
            if (m[i]) r[i*BDW +: BDW] = new_w[i*BDW +: BDW];
        return r;
    endfunction

    // Block RAM model: per-block write enables, registered read with latency 1
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < (1<<AW); a++) mem[a] <= init_word(AW'(a));
            bank_rdata <= '0;
        end else if (bank_en) begin
            for (int i = 0; i < BC; i++)
                if (bank_we[i]) mem[bank_addr][i*BDW +: BDW] <= bank_wdata[i*BDW +: BDW];
            if (bank_we == '0) bank_rdata <= mem[bank_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = 9'h1AA; rd_addr = 9'h155; wr_data = {BW{1'b1}}; wr_mask = 4'hF;
        repeat (2) @(negedge clk);
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else n_pass++;
        n_checks++; if (rd_ready !== 1'b0) $display("FAIL reset_rd_ready: got %b want 0", rd_ready); else n_pass++;
        n_checks++; if (bank_en !== 1'b0) $display("FAIL reset_bank_en: got %b want 0", bank_en); else n_pass++;
        n_checks++; if (bank_we !== 4'h0) $display("FAIL reset_bank_we: got %h want 0", bank_we); else n_pass++;
        n_checks++; if (bank_addr !== 9'h000) $display("FAIL reset_bank_addr: got %h want 0", bank_addr); else n_pass++;
        n_checks++; if (bank_wdata !== {BW{1'b0}}) $display("FAIL reset_bank_wdata: got %h want 0", bank_wdata); else n_pass++;
        n_checks++; if (rd_data_valid !== 1'b0) $display("FAIL reset_rd_data_valid: got %b want 0", rd_data_valid); else n_pass++;
        n_checks++; if (rd_data !== {BW{1'b0}}) $display("FAIL reset_rd_data: got %h want 0", rd_data); else n_pass++;
        for (int a = 0; a < (1<<AW); a++) ref_mem[a] = init_word(AW'(a));
        mem_init = 1'b0;
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [BW-1:0] exp_w;
        exp_w = ref_mem[9'h012];
        rd_valid = 1'b1; rd_addr = 9'h012;
        #1;
        n_checks++; if (rd_ready !== 1'b1) $display("FAIL single_read_ready: got %b want 1", rd_ready); else n_pass++;
        @(negedge clk);
        rd_valid = 1'b0;
        n_checks++;
        if (bank_en !== 1'b1 || bank_we !== 4'h0 || bank_addr !== 9'h012)
            $display("FAIL single_read_bank: got en=%b we=%h addr=%h want en=1 we=0 addr=012", bank_en, bank_we, bank_addr);
        else n_pass++;
        n_checks++; if (rd_data_valid !== 1'b0) $display("FAIL single_read_early_valid: got %b want 0", rd_data_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (rd_data_valid !== 1'b1) $display("FAIL single_read_valid: got %b want 1", rd_data_valid); else n_pass++;
        n_checks++; if (rd_data !== exp_w) $display("FAIL single_read_data: got %h want %h", rd_data, exp_w); else n_pass++;
        @(negedge clk);
        n_checks++; if (rd_data_valid !== 1'b0) $display("FAIL single_read_pulse: got %b want 0", rd_data_valid); else n_pass++;
        n_checks++; if (rd_data !== exp_w) $display("FAIL single_read_hold: got %h want %h", rd_data, exp_w); else n_pass++;
    endtask

    task automatic test_masked_write();
        logic [BW-1:0] d, exp_w;
        d = {$urandom, $urandom, $urandom, $urandom};
        exp_w = merge(ref_mem[9'h005], d, 4'b0101);
        ref_mem[9'h005] = exp_w;
        wr_valid = 1'b1; wr_addr = 9'h005; wr_data = d; wr_mask = 4'b0101;
        #1;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL masked_write_ready: got %b want 1", wr_ready); else n_pass++;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (bank_en !== 1'b1 || bank_we !== 4'b0101 || bank_addr !== 9'h005 || bank_wdata !== d)
            $display("FAIL masked_write_bank: got en=%b we=%b addr=%h wdata=%h want en=1 we=0101 addr=005 wdata=%h",
                     bank_en, bank_we, bank_addr, bank_wdata, d);
        else n_pass++;
        rd_valid = 1'b1; rd_addr = 9'h005;
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== exp_w)
            $display("FAIL masked_write_readback: got v=%b %h want v=1 %h", rd_data_valid, rd_data, exp_w);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write_then_read();
        logic [BW-1:0] d;
        d = {4{32'hA5A5_A5A5}};
        ref_mem[9'h010] = d;
        wr_valid = 1'b1; wr_addr = 9'h010; wr_data = d; wr_mask = 4'hF;
        #1;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL wtr_write_ready: got %b want 1", wr_ready); else n_pass++;
        @(negedge clk);
        idle_inputs();
        rd_valid = 1'b1; rd_addr = 9'h010;
        #1;
        n_checks++; if (rd_ready !== 1'b1) $display("FAIL wtr_read_ready: got %b want 1", rd_ready); else n_pass++;
        @(negedge clk);
        rd_valid = 1'b0;
        n_checks++;
        if (bank_en !== 1'b1 || bank_we !== 4'h0 || bank_addr !== 9'h010)
            $display("FAIL wtr_bank_read: got en=%b we=%h addr=%h want en=1 we=0 addr=010", bank_en, bank_we, bank_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== d)
            $display("FAIL wtr_data: got v=%b %h want v=1 %h", rd_data_valid, rd_data, d);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit exp_rd;
        int bad;
        bad = 0;
        wr_valid = 1'b1; wr_addr = 9'h020; wr_data = {4{32'h0F0F_0F0F}}; wr_mask = 4'hF;
        rd_valid = 1'b1; rd_addr = 9'h021;
        ref_mem[9'h020] = wr_data;
        for (int k = 0; k < 100; k++) begin
            #1;
            // With the guard the reader is served after every SL writes
            exp_rd = GUARD && ((k % (SL + 1)) == SL);
            n_checks++;
            if ((rd_valid && rd_ready) !== exp_rd || (wr_valid && wr_ready) !== !exp_rd) begin
                bad++;
                if (bad < 5)
                    $display("FAIL contention_cycle_%0d: got wr=%b rd=%b want wr=%b rd=%b",
                             k, wr_ready, rd_ready, !exp_rd, exp_rd);
            end else n_pass++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        n_checks++; if (rd_ready !== 1'b1) $display("FAIL contention_release: got rd_ready=%b want 1", rd_ready); else n_pass++;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int seen;
        seen = 0;
        rd_valid = 1'b1; rd_addr = 9'h033;
        #1;
        n_checks++; if (rd_ready !== 1'b1) $display("FAIL rmr_ready: got %b want 1", rd_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0 || rd_ready !== 1'b0)
            $display("FAIL rmr_ready_in_reset: got wr=%b rd=%b want 0 0", wr_ready, rd_ready);
        else n_pass++;
        if (rd_data_valid === 1'b1) seen++;
        @(negedge clk);
        rst = 1'b0; idle_inputs();
        n_checks++;
        if (bank_en !== 1'b0 || bank_we !== 4'h0 || bank_addr !== 9'h000 || bank_wdata !== {BW{1'b0}} ||
            rd_data_valid !== 1'b0 || rd_data !== {BW{1'b0}})
            $display("FAIL rmr_outputs: got en=%b we=%h addr=%h v=%b data=%h want all 0",
                     bank_en, bank_we, bank_addr, rd_data_valid, rd_data);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (rd_data_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) $display("FAIL rmr_no_return: got %0d valid pulses want 0", seen); else n_pass++;
    endtask

    task automatic test_random(input int n);
        int            pend;
        bit            prev_wr, prev_rd, gw, gr, force_rd, exp_v;
        logic [AW-1:0] prev_addr;
        logic [BC-1:0] prev_mask;
        logic [BW-1:0] prev_wdata;
        logic [BW-1:0] exp_q [$];
        int            due_q [$];
        pend = 0; prev_wr = 1'b0; prev_rd = 1'b0;
        prev_addr = '0; prev_mask = '0; prev_wdata = '0;
        idle_inputs();
        for (int c = 0; c < n + 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bank_en !== (prev_wr || prev_rd)) $display("FAIL rand_bank_en c=%0d: got %b want %b", c, bank_en, prev_wr || prev_rd);
            else n_pass++;
            n_checks++;
            if (bank_we !== (prev_wr ? prev_mask : 4'h0)) $display("FAIL rand_bank_we c=%0d: got %h want %h", c, bank_we, prev_wr ? prev_mask : 4'h0);
            else n_pass++;
            if (prev_wr || prev_rd) begin
                n_checks++;
                if (bank_addr !== prev_addr) $display("FAIL rand_bank_addr c=%0d: got %h want %h", c, bank_addr, prev_addr);
                else n_pass++;
            end
            if (prev_wr) begin
                n_checks++;
                if (bank_wdata !== prev_wdata) $display("FAIL rand_bank_wdata c=%0d: got %h want %h", c, bank_wdata, prev_wdata);
                else n_pass++;
            end
            exp_v = (due_q.size() > 0) && (due_q[0] == c);
            n_checks++;
            if (rd_data_valid !== exp_v) $display("FAIL rand_rd_valid c=%0d: got %b want %b", c, rd_data_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if (rd_data !== exp_q[0]) $display("FAIL rand_rd_data c=%0d: got %h want %h", c, rd_data, exp_q[0]);
                else n_pass++;
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            // Requesters drop only after being served, and hold payload until then
            if (prev_wr) wr_valid = 1'b0;
            if (prev_rd) rd_valid = 1'b0;
            if (c < n) begin
                if (!wr_valid && $urandom_range(0, 1) == 1) begin
                    wr_valid = 1'b1;
                    wr_addr  = AW'($urandom_range(0, 15));
                    wr_data  = {$urandom, $urandom, $urandom, $urandom};
                    wr_mask  = BC'($urandom_range(0, 15));
                end
                if (!rd_valid && $urandom_range(0, 2) != 0) begin
                    rd_valid = 1'b1;
                    rd_addr  = AW'($urandom_range(0, 15));
                end
            end
            #1;
            force_rd = GUARD && (pend >= SL);
            if (wr_valid && rd_valid) begin
                gw = !force_rd; gr = force_rd;
            end else begin
                gw = wr_valid; gr = rd_valid;
            end
            n_checks++;
            if ((wr_valid && wr_ready) !== gw || (rd_valid && rd_ready) !== gr)
                $display("FAIL rand_grant c=%0d: got wr=%b rd=%b want wr=%b rd=%b",
                         c, wr_valid && wr_ready, rd_valid && rd_ready, gw, gr);
            else n_pass++;
            if (!rd_valid || gr) pend = 0;
            else if (gw && pend < SL) pend = pend + 1;
            if (gw) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_mask);
            if (gr) begin
                exp_q.push_back(ref_mem[rd_addr]);
                due_q.push_back(c + 1 + RL);
            end
            prev_wr = gw; prev_rd = gr;
            prev_addr  = gw ? wr_addr : rd_addr;
            prev_mask  = wr_mask;
            prev_wdata = wr_data;
        end
        n_checks++;
        if (due_q.size() !== 0) $display("FAIL rand_drain: got %0d outstanding reads want 0", due_q.size());
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        mem_init = 1'b1;
        test_reset();
        test_single_read();
        test_masked_write();
        test_write_then_read();
        test_contention();
        test_reset_mid_read();
        test_random(400);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
